// File: rtl/led_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package    : led_pkg                                                   |
// | Purpose    : Shared types and constants for the LED pattern generator. |
// |              led_mode_t encodes the per-channel operating mode as it   |
// |              appears on the 2-bit cfg_mode write field.                |
// | Revision   : 1.0 - initial multi-channel release                       |
// +------------------------------------------------------------------------+
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_BLINK   = 2'd2,
    LED_BREATHE = 2'd3
  } led_mode_t;

  // Channel 0 comes out of reset blinking, like the single-LED blinker it
  // replaces: a half-period of TICK_HZ/4 ticks gives a ~2 Hz full cycle.
  localparam led_mode_t LED_CH0_RST_MODE = LED_BLINK;
  localparam int        LED_CH0_RST_DIV  = 4;

endpackage
`default_nettype wire

// File: rtl/led_channel.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : led_channel                                               |
// | Purpose    : One LED channel: mode/period/phase state and registered   |
// |              output. Timing is counted in prescaler ticks.             |
// | Macro      : LED_BREATHE_EN - adds duty/direction state and the PWM    |
// |              compare; without it mode 3 behaves as BLINK.              |
// | Ports      : clk_i, rst_i (async, active-high)                         |
// |              tick_i      - shared prescaler pulse                      |
// |              pwm_cnt_i   - shared PWM counter (breathe builds only)    |
// |              wr_en_i     - decoded write strobe for this channel       |
// |              wr_mode_i   - mode to load                                |
// |              wr_period_i - period to load, in ticks                    |
// |              led_o       - registered LED drive                        |
// | Revision   : 1.0 - initial multi-channel release                       |
// +------------------------------------------------------------------------+
module led_channel
  import led_pkg::*;
#(
`ifdef LED_BREATHE_EN
  parameter int        PWM_W      = 8,
`endif
  parameter int        PERIOD_W   = 10,
  parameter led_mode_t RST_MODE   = LED_OFF,
  parameter int        RST_PERIOD = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tick_i,
`ifdef LED_BREATHE_EN
  input  logic [PWM_W-1:0]    pwm_cnt_i,
`endif
  input  logic                wr_en_i,
  input  led_mode_t           wr_mode_i,
  input  logic [PERIOD_W-1:0] wr_period_i,
  output logic                led_o
);

  led_mode_t           mode_q,   mode_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] phase_q,  phase_d;
  logic                out_q,    out_d;
  logic                led_q,    led_d;
  logic [PERIOD_W-1:0] last_phase;
  logic                wrap;
`ifdef LED_BREATHE_EN
  logic [PWM_W-1:0]    duty_q,   duty_d;
  logic                down_q,   down_d;
`endif

  // A period of 0 is treated as 1, so the last phase is 0 in both cases.
  assign last_phase = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
  assign wrap       = (phase_q == last_phase);

  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    phase_d  = phase_q;
    out_d    = out_q;
`ifdef LED_BREATHE_EN
    duty_d   = duty_q;
    down_d   = down_q;
`endif
    if (wr_en_i) begin
      // A write on a tick cycle wins: the tick is dropped for this channel.
      mode_d   = wr_mode_i;
      period_d = wr_period_i;
      phase_d  = '0;
      out_d    = 1'b0;
`ifdef LED_BREATHE_EN
      duty_d   = '0;
      down_d   = 1'b0;
`endif
    end else if (mode_q == LED_OFF || mode_q == LED_ON) begin
      phase_d = '0;
    end else if (tick_i) begin
      if (wrap) begin
        phase_d = '0;
`ifdef LED_BREATHE_EN
        if (mode_q == LED_BREATHE) begin
          // The extreme value is held for one step while direction flips.
          if (!down_q) begin
            if (duty_q == '1) down_d = 1'b1;
            else              duty_d = duty_q + PWM_W'(1);
          end else begin
            if (duty_q == '0) down_d = 1'b0;
            else              duty_d = duty_q - PWM_W'(1);
          end
        end else begin
          out_d = ~out_q;
        end
`else
        out_d = ~out_q;
`endif
      end else begin
        phase_d = phase_q + PERIOD_W'(1);
      end
    end
  end

  // The LED register follows the current state, so it lags the state
  // update that causes it by one cycle.
  always_comb begin
    led_d = 1'b0;
    case (mode_q)
      LED_OFF:     led_d = 1'b0;
      LED_ON:      led_d = 1'b1;
      LED_BLINK:   led_d = out_q;
`ifdef LED_BREATHE_EN
      LED_BREATHE: led_d = (pwm_cnt_i < duty_q);
`else
      LED_BREATHE: led_d = out_q;
`endif
      default:     led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q   <= RST_MODE;
      period_q <= PERIOD_W'(RST_PERIOD);
      phase_q  <= '0;
      out_q    <= 1'b0;
      led_q    <= 1'b0;
`ifdef LED_BREATHE_EN
      duty_q   <= '0;
      down_q   <= 1'b0;
`endif
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      phase_q  <= phase_d;
      out_q    <= out_d;
      led_q    <= led_d;
`ifdef LED_BREATHE_EN
      duty_q   <= duty_d;
      down_q   <= down_d;
`endif
    end
  end

  assign led_o = led_q;

endmodule
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : led_pattern_gen                                           |
// | Purpose    : Multi-channel LED pattern generator. Shared tick          |
// |              prescaler, optional shared PWM counter, write decode and  |
// |              NUM_LEDS led_channel instances.                           |
// | Macro      : LED_BREATHE_EN - enables the BREATHE mode hardware.       |
// | Ports      : clk_16mhz  - system clock                                 |
// |              rst        - async active-high reset (~pll_locked)        |
// |              cfg_valid/cfg_ready - write handshake                     |
// |              cfg_chan, cfg_mode, cfg_period - write payload            |
// |              tick       - one-cycle prescaler pulse                    |
// |              leds       - registered LED drive, active-high            |
// | Revision   : 1.0 - initial multi-channel release                       |
// +------------------------------------------------------------------------+
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NUM_LEDS = 4,
  parameter int CLK_HZ   = 16_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int PERIOD_W = 10,
  parameter int PWM_W    = 8
) (
  input  logic                                            clk_16mhz,
  input  logic                                            rst,
  input  logic                                            cfg_valid,
  output logic                                            cfg_ready,
  input  logic [((NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1)-1:0] cfg_chan,
  input  logic [1:0]                                      cfg_mode,
  input  logic [PERIOD_W-1:0]                             cfg_period,
  output logic                                            tick,
  output logic [NUM_LEDS-1:0]                             leds
);

  localparam int             CHAN_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int             DIV      = CLK_HZ / TICK_HZ;
  localparam int             CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  if (NUM_LEDS < 1 || NUM_LEDS > 16 || TICK_HZ < 1 || (CLK_HZ % TICK_HZ) != 0 ||
      PERIOD_W < 1 || PWM_W < 1) begin : g_param_check
    $error("led_pattern_gen: illegal parameter combination");
  end

  logic             ready_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_last;
  logic             accept;
  led_mode_t        cfg_mode_e;

  assign cnt_last = (cnt_q == CNT_LAST);
  assign cnt_d    = cnt_last ? '0 : cnt_q + CNT_W'(1);

  // Gating with ready keeps tick low in reset even when DIV is 1.
  assign tick       = ready_q & cnt_last;
  assign cfg_ready  = ready_q;
  assign accept     = cfg_valid & ready_q;
  assign cfg_mode_e = led_mode_t'(cfg_mode);

  always_ff @(posedge clk_16mhz or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ready_q <= 1'b1;
      cnt_q   <= cnt_d;
    end
  end

`ifdef LED_BREATHE_EN
  logic [PWM_W-1:0] pwm_cnt_q;

  always_ff @(posedge clk_16mhz or posedge rst) begin
    if (rst) pwm_cnt_q <= '0;
    else     pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
  end
`endif

  // Writes to channel numbers >= NUM_LEDS match no instance and are dropped.
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    logic wr_en;
    assign wr_en = accept && (cfg_chan == CHAN_W'(i));

    led_channel #(
`ifdef LED_BREATHE_EN
      .PWM_W      (PWM_W),
`endif
      .PERIOD_W   (PERIOD_W),
      .RST_MODE   ((i == 0) ? LED_CH0_RST_MODE : LED_OFF),
      .RST_PERIOD ((i == 0) ? (TICK_HZ / LED_CH0_RST_DIV) : 0)
    ) u_chan (
      .clk_i       (clk_16mhz),
      .rst_i       (rst),
      .tick_i      (tick),
`ifdef LED_BREATHE_EN
      .pwm_cnt_i   (pwm_cnt_q),
`endif
      .wr_en_i     (wr_en),
      .wr_mode_i   (cfg_mode_e),
      .wr_period_i (cfg_period),
      .led_o       (leds[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : tb_led_pattern_gen                                        |
// | Purpose    : Scoreboard bench for led_pattern_gen. A closed-form model |
// |              predicts {cfg_ready, tick, leds} for every clock edge     |
// |              from tick counts since each channel's last write.         |
// | Revision   : 1.0                                                       |
// +------------------------------------------------------------------------+
module tb_led_pattern_gen;

  localparam int NUM_LEDS = 5;
  localparam int CLK_HZ   = 1000;
  localparam int TICK_HZ  = 100;
  localparam int PERIOD_W = 10;
  localparam int PWM_W    = 2;
  localparam int DIV      = CLK_HZ / TICK_HZ;
  localparam int CHAN_W   = 3;
  localparam int OW       = NUM_LEDS + 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [CHAN_W-1:0]   cfg_chan = '0;
  logic [1:0]          cfg_mode = '0;
  logic [PERIOD_W-1:0] cfg_period = '0;
  logic                tick;
  logic [NUM_LEDS-1:0] leds;

  led_pattern_gen #(
    .NUM_LEDS (NUM_LEDS),
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .PERIOD_W (PERIOD_W),
    .PWM_W    (PWM_W)
  ) dut (
    .clk_16mhz  (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_chan   (cfg_chan),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .tick       (tick),
    .leds       (leds)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  int k = 0;                 // clock edges since reset release
  logic [OW-1:0] exp_q[$];

  // Model: each channel's mode, period and the edge at which its config
  // took effect (0 for the reset configuration).
  int m_mode[NUM_LEDS];
  int m_per [NUM_LEDS];
  int m_c   [NUM_LEDS];

  function automatic void model_reset();
    for (int i = 0; i < NUM_LEDS; i++) begin
      m_mode[i] = (i == 0) ? 2 : 0;
      m_per[i]  = (i == 0) ? TICK_HZ / 4 : 0;
      m_c[i]    = 0;
    end
  endfunction

  // Channel output state after edge kk.
  function automatic logic model_led(int ch, int kk);
    int eff, n, s, mx, r, duty;
    eff = (m_per[ch] == 0) ? 1 : m_per[ch];
    // Ticks take effect on edges that are multiples of DIV; count those
    // strictly after the config edge, up to kk.
    n  = kk / DIV - m_c[ch] / DIV;
    s  = n / eff;
    mx = (1 << PWM_W) - 1;
    case (m_mode[ch])
      0: return 1'b0;
      1: return 1'b1;
      3: begin
`ifdef LED_BREATHE_EN
        r    = s % (2 * mx + 2);
        duty = (r <= mx) ? r : (2 * mx + 1 - r);
        return ((kk % (1 << PWM_W)) < duty);
`else
        r = 0; duty = 0;
        return (s % 2) == 1;
`endif
      end
      default: begin
        r = 0; duty = 0;
        return (s % 2) == 1;
      end
    endcase
  endfunction

  // Expected {cfg_ready, tick, leds} after edge kk+1.
  function automatic logic [OW-1:0] model_out(int kk);
    logic [OW-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_LEDS; i++) v[i] = model_led(i, kk);
    v[NUM_LEDS]     = ((kk + 1) % DIV) == (DIV - 1);
    v[NUM_LEDS + 1] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // One cycle of stimulus: record the expectation for the next edge, drive
  // the write (if any), and let the model see it take effect at that edge.
  task automatic step(input bit wr, input int ch, input int md, input int per);
    exp_q.push_back(model_out(k));
    cfg_valid  = wr;
    cfg_chan   = CHAN_W'(ch);
    cfg_mode   = 2'(md);
    cfg_period = PERIOD_W'(per);
    if (wr && ch < NUM_LEDS) begin
      m_mode[ch] = md;
      m_per[ch]  = per;
      m_c[ch]    = k + 1;
    end
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0);
  endtask

  // Monitor: every edge presents a new output word; compare with the
  // oldest expectation.
  always @(posedge clk) begin
    logic [OW-1:0] want;
    #1;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty at edge %0d", k);
      end else begin
        want = exp_q.pop_front();
        total++;
        if ({cfg_ready, tick, leds} !== want) begin
          bad++;
          $display("FAIL out_edge%0d: got ready/tick/leds=%b expected=%b",
                   k, {cfg_ready, tick, leds}, want);
        end
      end
    end
  end

  initial begin
    // Reset held for 3 cycles.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_leds", 32'(leds), 32'h0);
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_ready", 32'(cfg_ready), 32'h0);

    // Release between edges.
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    k = 0;
    check("ready_before_first_edge", 32'(cfg_ready), 32'h0);
    mon_en = 1'b1;
    idle(1);

    // Default blink on channel 0 (toggles at 250 and 500 cycles).
    idle(520);

    // ON then OFF on channel 2.
    step(1'b1, 2, 1, 0); idle(5);
    step(1'b1, 2, 0, 0); idle(5);

    // BLINK period 3, then period 0.
    step(1'b1, 1, 2, 3); idle(100);
    step(1'b1, 1, 2, 0); idle(50);

    // Write exactly on a tick cycle.
    for (int g = 0; g < DIV && (k % DIV) != (DIV - 1); g++) idle(1);
    step(1'b1, 1, 2, 2); idle(60);

    // Out-of-range channels are discarded.
    step(1'b1, 5, 1, 0);
    step(1'b1, 7, 1, 0);
    idle(10);

    // BREATHE (BLINK period 1 when breathe is not built in).
    step(1'b1, 3, 3, 1); idle(200);

    // Randomised writes.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0)
        step(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 4)));
      else
        idle(1);
    end

    // Async reset while channel 1 blinks with its LED high.
    step(1'b1, 1, 2, 1);
    for (int g = 0; g < 100 && !model_led(1, k - 1); g++) idle(1);
    check("led1_high_before_reset", 32'(model_led(1, k - 1)), 32'h1);
    #4;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check("async_reset_leds", 32'(leds), 32'h0);
    check("async_reset_ready", 32'(cfg_ready), 32'h0);
    check("async_reset_tick", 32'(tick), 32'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    k = 0;
    mon_en = 1'b1;
    idle(1);
    idle(300);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
